div: RTL and testbench
======================

# div

Sequential restoring divider; the inverse of the team's `mult` multiplier. It uses the same `ctrl_enable`/`ctrl_done` handshake and the same width convention, so a `mult` result can be fed back as the dividend to recover the operands. The block produces one quotient bit per clock. It is used wherever the PRNG datapath needs quotient and remainder, for example range reduction of generator output.

## Interface
- `in_width`, 4: divisor and remainder width.
- `out_width`, `in_width*2`: dividend and quotient width.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `data_dividend`  in  `out_width`  unsigned dividend; sampled at start.
- `data_divisor`  in  `in_width`  unsigned divisor; sampled at start.
- `data_quotient`  out  `out_width`  unsigned quotient.
- `data_remainder`  out  `in_width`  unsigned remainder.
- `ctrl_enable`  in  1  start request; held high until `ctrl_done` is seen.
- `ctrl_done`  out  1  results valid.
- `ctrl_div_by_zero`  out  1  last operation had divisor 0.

## Operation
- **Reset state:** `rst` low asynchronously forces state IDLE and clears every register. All outputs read 0: quotient, remainder, `ctrl_done`, `ctrl_div_by_zero`.
- **States:** IDLE, BUSY, DONE.
- **IDLE:**
  - On an edge with `ctrl_enable`=1, latch both operands, clear the partial remainder, set iteration counter = `out_width`, clear `ctrl_div_by_zero`.
  - Go to BUSY, or to DONE directly if divisor = 0.
  - Outputs keep their previous values while idle.
- **BUSY, each edge:**
  - Partial remainder P (`in_width`+1 bits) = {P, next dividend MSB}.
  - If P >= divisor: P -= divisor and shift in quotient bit 1; else shift in 0.
  - Decrement the counter. After the edge that consumes the last dividend bit, go to DONE.
- **BUSY, ignored inputs:**
  - Operand changes are ignored (operands are latched).
  - `ctrl_enable` falling is ignored; the operation always completes.
- **DONE:**
  - `ctrl_done`=1. Quotient and remainder are registered and stable.
  - When `ctrl_enable` is sampled 0, go to IDLE and drop `ctrl_done`. Results and `ctrl_div_by_zero` hold until the next start.
  - If `ctrl_enable` is still 1, stay in DONE. A new operation needs `ctrl_enable` to return low first; there is no auto-restart.
- **Divide by zero:** quotient = all ones, remainder = 0, `ctrl_div_by_zero`=1, no iterations.
- **Width rules:**
  - Remainder < divisor always, so it fits in `in_width`.
  - Quotient fits in `out_width` for any nonzero divisor; there is no overflow case.
  - Internal compare/subtract uses `in_width`+1 bits so no carry is lost.

## Timing
- **Start:** capture edge C is the first rising edge in IDLE with `ctrl_enable`=1.
- **Normal latency:** `ctrl_done` rises at edge C+`out_width` (8 cycles at default), registered together with the final quotient bit.
- **Divide-by-zero latency:** `ctrl_done` rises at edge C+1.
- **Done pulse:** `ctrl_done` stays high for at least 1 cycle. It falls on the first edge in DONE that samples `ctrl_enable`=0.
- **Early enable drop:** if `ctrl_enable` dropped during BUSY, `ctrl_done` is high for exactly 1 cycle.
- **Next start:** the earliest next capture is the edge after `ctrl_done` falls, once `ctrl_enable` is high again.
- **Output glitches:** quotient and remainder may change during BUSY and are only valid while `ctrl_done`=1 or afterwards in IDLE.
- **Reset mid-operation:** immediate return to IDLE with all outputs 0. `ctrl_done` never asserts for the aborted operation. The first edge after `rst` rises may be a capture edge.

## Test plan
- **Basic, inverse of the `mult` check:** 35 / 5 -> quotient 7, remainder 0, `ctrl_div_by_zero`=0. `ctrl_done` rises exactly 8 cycles after capture.
- **Full width and remainders:**
  - 200 / 7 -> 28 r 4.
  - 255 / 1 -> 255 r 0.
  - 255 / 15 -> 17 r 0.
  - 3 / 9 -> 0 r 3.
- **Divide by zero:** 100 / 0 -> quotient 255, remainder 0, `ctrl_div_by_zero`=1, `ctrl_done` at C+1. A following 9 / 3 -> 3 r 0 clears the flag.
- **Reset mid-BUSY:** start 200 / 7, pull `rst` low at C+3 -> all outputs 0 asynchronously and no `ctrl_done`. After release, 50 / 6 -> 8 r 2.
- **Handshake:**
  - Hold `ctrl_enable` 3 cycles past done -> `ctrl_done` stays high and there is no restart.
  - Drop `ctrl_enable` at C+2 -> the operation completes and `ctrl_done` pulses 1 cycle.
  - Change operands during BUSY -> no effect on the result.
- **Sweep:** all 256×16 operand pairs back to back, each compared against `/` and `%`, with the divide-by-zero rule checked for divisor 0.

Source files
------------

// File: rtl/div.sv
// Sequential restoring divider: one quotient bit per clock, mult-style enable/done handshake.
// Divide by zero skips iteration and reports all-ones quotient with ctrl_div_by_zero set.
module div #(
    parameter int in_width  = 4,
    parameter int out_width = in_width * 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [out_width-1:0] data_dividend,
    input  logic [in_width-1:0]  data_divisor,
    output logic [out_width-1:0] data_quotient,
    output logic [in_width-1:0]  data_remainder,
    input  logic                 ctrl_enable,
    output logic                 ctrl_done,
    output logic                 ctrl_div_by_zero
);

    localparam int CW = $clog2(out_width + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state;
    logic [out_width-1:0] dvd;
    logic [in_width-1:0]  dvs;
    logic [CW-1:0]        cnt;

    logic [in_width:0]    p_shift;
    logic [in_width-1:0]  p_sub;
    logic                 ge;

    // Remainder register is in_width wide; the extra compare bit lives only in p_shift.
    always_comb begin
        p_shift = {data_remainder, dvd[out_width-1]};
        ge      = p_shift >= {1'b0, dvs};
        p_sub   = p_shift[in_width-1:0] - dvs;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            dvd              <= '0;
            dvs              <= '0;
            cnt              <= '0;
            data_quotient    <= '0;
            data_remainder   <= '0;
            ctrl_done        <= 1'b0;
            ctrl_div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ctrl_enable) begin
                        dvd              <= data_dividend;
                        dvs              <= data_divisor;
                        cnt              <= CW'(out_width);
                        data_remainder   <= '0;
                        ctrl_div_by_zero <= (data_divisor == '0);
                        if (data_divisor == '0) begin
                            data_quotient <= '1;
                            state         <= DONE;
                        end else begin
                            data_quotient <= '0;
                            state         <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    data_remainder <= ge ? p_sub : p_shift[in_width-1:0];
                    data_quotient  <= {data_quotient[out_width-2:0], ge};
                    dvd            <= {dvd[out_width-2:0], 1'b0};
                    cnt            <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= DONE;
                        ctrl_done <= 1'b1;
                    end
                end
                DONE: begin
                    // Divide-by-zero enters DONE with done low; raise it one edge later.
                    if (!ctrl_done) begin
                        ctrl_done <= 1'b1;
                    end else if (!ctrl_enable) begin
                        ctrl_done <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: driver pushes expected results, monitor pops on each ctrl_done rise.
module tb_div;

    logic       clk;
    logic       rst;
    logic [7:0] data_dividend;
    logic [3:0] data_divisor;
    logic [7:0] data_quotient;
    logic [3:0] data_remainder;
    logic       ctrl_enable;
    logic       ctrl_done;
    logic       ctrl_div_by_zero;

    typedef struct {
        int q;
        int r;
        int dbz;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    logic prev_done = 1'b0;

    div #(.in_width(4), .out_width(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .data_dividend    (data_dividend),
        .data_divisor     (data_divisor),
        .data_quotient    (data_quotient),
        .data_remainder   (data_remainder),
        .ctrl_enable      (ctrl_enable),
        .ctrl_done        (ctrl_done),
        .ctrl_div_by_zero (ctrl_div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input int a, input int b);
        exp_t e;
        if (b == 0) begin
            e.q = 255; e.r = 0; e.dbz = 1;
        end else begin
            e.q = a / b; e.r = a % b; e.dbz = 0;
        end
        return e;
    endfunction

    // Monitor: every rising ctrl_done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (ctrl_done && !prev_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("quotient", int'(data_quotient), e.q);
                chk("remainder", int'(data_remainder), e.r);
                chk("div_by_zero", int'(ctrl_div_by_zero), e.dbz);
            end
        end
        prev_done = ctrl_done;
    end

    task automatic run_op(input int a, input int b, input int hold, input int drop_at,
                          input bit scramble);
        exp_t e;
        int   lat;
        bit   seen;
        @(negedge clk);
        data_dividend = 8'(a);
        data_divisor  = 4'(b);
        ctrl_enable   = 1'b1;
        e = model(a, b);
        sb.push_back(e);
        @(posedge clk);
        lat  = 0;
        seen = 1'b0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (ctrl_done) begin
                seen = 1'b1;
                lat  = c;
            end
            if (scramble) begin
                data_dividend = 8'($urandom);
                data_divisor  = 4'($urandom);
            end
            if (c == drop_at) ctrl_enable = 1'b0;
        end
        if (!seen) begin
            chk("done_timeout", 0, 1);
            void'(sb.pop_back());
            ctrl_enable = 1'b0;
            repeat (3) @(posedge clk);
            return;
        end
        chk("latency", lat, (b == 0) ? 1 : 8);
        if (drop_at > 0) begin
            @(posedge clk);
            #1;
            chk("done_one_cycle", int'(ctrl_done), 0);
        end else begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1;
                chk("done_held", int'(ctrl_done), 1);
                chk("no_restart_q", int'(data_quotient), e.q);
            end
            @(negedge clk);
            ctrl_enable = 1'b0;
            @(posedge clk);
            #1;
            chk("done_fall", int'(ctrl_done), 0);
        end
        chk("idle_hold_q", int'(data_quotient), e.q);
        chk("idle_hold_r", int'(data_remainder), e.r);
        chk("idle_hold_dbz", int'(ctrl_div_by_zero), e.dbz);
    endtask

    initial begin
        rst           = 1'b0;
        ctrl_enable   = 1'b0;
        data_dividend = '0;
        data_divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_q", int'(data_quotient), 0);
        chk("reset_r", int'(data_remainder), 0);
        chk("reset_done", int'(ctrl_done), 0);
        chk("reset_dbz", int'(ctrl_div_by_zero), 0);
        @(negedge clk);
        rst = 1'b1;

        run_op(35, 5, 0, 0, 1'b0);
        run_op(200, 7, 0, 0, 1'b0);
        run_op(255, 1, 0, 0, 1'b0);
        run_op(255, 15, 0, 0, 1'b0);
        run_op(3, 9, 0, 0, 1'b0);
        run_op(100, 0, 0, 0, 1'b0);
        run_op(9, 3, 0, 0, 1'b0);

        // Abort mid-operation: no expectation pushed, so any done is flagged by the monitor.
        @(negedge clk);
        data_dividend = 8'd200;
        data_divisor  = 4'd7;
        ctrl_enable   = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_q", int'(data_quotient), 0);
        chk("abort_r", int'(data_remainder), 0);
        chk("abort_done", int'(ctrl_done), 0);
        chk("abort_dbz", int'(ctrl_div_by_zero), 0);
        ctrl_enable = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", int'(ctrl_done), 0);
        end
        @(negedge clk);
        rst = 1'b1;
        run_op(50, 6, 0, 0, 1'b0);

        run_op(77, 4, 3, 0, 1'b0);
        run_op(200, 7, 0, 2, 1'b0);
        run_op(123, 5, 1, 0, 1'b1);

        for (int a = 0; a < 256; a++)
            for (int b = 0; b < 16; b++)
                run_op(a, b, 0, 0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            int a;
            int b;
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 15));
            run_op(a, b, int'($urandom_range(0, 3)),
                   (b != 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0,
                   1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
